l1_dcache: RTL and testbench



---
 rtl/l1_pkg.sv | 17 +
 rtl/l1_line_store.sv | 53 +++++
 rtl/l1_dcache.sv | 154 +++++++++++++++
 tb/tb_l1_dcache.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/l1_pkg.sv
// Shared types and default geometry for the direct-mapped write-through L1 data cache.
package l1_pkg;

    localparam int DEF_N     = 32;
    localparam int DEF_AW    = 15;
    localparam int DEF_IDX   = 4;
    localparam int DEF_TW    = DEF_AW - DEF_IDX;
    localparam int DEF_LINES = 1 << DEF_IDX;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_MISS = 2'd1,
        ST_WR_THRU = 2'd2,
        ST_WR_DONE = 2'd3
    } l1_state_t;

endpackage

// File: rtl/l1_line_store.sv
// Valid/tag/data arrays: one combinational lookup port, one write port, one snoop-invalidate port.
module l1_line_store #(
    parameter int n   = 32,
    parameter int IDX = 4,
    parameter int TW  = 11
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IDX-1:0] rd_idx,
    input  logic [TW-1:0]  rd_tag,
    output logic           hit,
    output logic [n-1:0]   rd_data,
    input  logic           wr_en,
    input  logic [IDX-1:0] wr_idx,
    input  logic [TW-1:0]  wr_tag,
    input  logic [n-1:0]   wr_data,
    input  logic           wr_valid,
    input  logic           snoop_en,
    input  logic [IDX-1:0] snoop_idx,
    input  logic [TW-1:0]  snoop_tag
);
    localparam int LINES = 1 << IDX;

    logic [LINES-1:0] valid_r;
    logic [TW-1:0]    tag_r  [LINES];
    logic [n-1:0]     data_r [LINES];

    assign hit     = valid_r[rd_idx] && (tag_r[rd_idx] == rd_tag);
    assign rd_data = data_r[rd_idx];

    // Valid bits: a write issued in the same cycle as a snoop overrides it.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
        end else begin
            if (snoop_en && (tag_r[snoop_idx] == snoop_tag)) begin
                valid_r[snoop_idx] <= 1'b0;
            end
            if (wr_en) begin
                valid_r[wr_idx] <= wr_valid;
            end
        end
    end

    // Tag and data payload; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with a req/ack bus and snoop invalidate.
module l1_dcache
    import l1_pkg::*;
#(
    parameter int n   = DEF_N,
    parameter int AW  = DEF_AW,
    parameter int IDX = DEF_IDX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_control,
    input  logic          store_control,
    input  logic [AW-1:0] address,
    input  logic [n-1:0]  dmem_wdata,
    output logic [n-1:0]  dmem_rdata,
    output logic          L1_busy,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [n-1:0]  mem_wdata,
    input  logic          mem_ack,
    input  logic [n-1:0]  mem_rdata,
    input  logic          snoop_inv,
    input  logic [AW-1:0] snoop_addr
);
    localparam int TW = AW - IDX;

    l1_state_t    state_r;
    logic         hit_s;
    logic [n-1:0] line_data_s;
    logic         ack_s;
    logic         kill_s;
    logic         wr_en_s;
    logic         wr_valid_s;
    logic [n-1:0] wr_data_s;

    assign ack_s = mem_ack && mem_req;

    l1_line_store #(
        .n   (n),
        .IDX (IDX),
        .TW  (TW)
    ) u_lines (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (address[IDX-1:0]),
        .rd_tag    (address[AW-1:IDX]),
        .hit       (hit_s),
        .rd_data   (line_data_s),
        .wr_en     (wr_en_s),
        .wr_idx    (mem_addr[IDX-1:0]),
        .wr_tag    (mem_addr[AW-1:IDX]),
        .wr_data   (wr_data_s),
        .wr_valid  (wr_valid_s),
        .snoop_en  (snoop_inv),
        .snoop_idx (snoop_addr[IDX-1:0]),
        .snoop_tag (snoop_addr[AW-1:IDX])
    );

    // Line write on bus completion; a snoop to the very same word leaves the line invalid.
    always_comb begin
        kill_s     = snoop_inv && (snoop_addr == mem_addr);
        wr_valid_s = !kill_s;
        wr_en_s    = 1'b0;
        wr_data_s  = mem_wdata;
        case (state_r)
            ST_RD_MISS: begin
                wr_en_s   = ack_s;
                wr_data_s = mem_rdata;
            end
            ST_WR_THRU: begin
                wr_en_s   = ack_s && hit_s;
                wr_data_s = mem_wdata;
            end
            default: begin
                wr_en_s   = 1'b0;
                wr_data_s = mem_wdata;
            end
        endcase
    end

    // Core-facing stall and load data.
    always_comb begin
        L1_busy = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (store_control) begin
                    L1_busy = 1'b1;
                end else if (load_control) begin
                    L1_busy = !hit_s;
                end else begin
                    L1_busy = 1'b0;
                end
            end
            ST_RD_MISS: L1_busy = 1'b1;
            ST_WR_THRU: L1_busy = 1'b1;
            ST_WR_DONE: L1_busy = 1'b0;
            default:    L1_busy = 1'b1;
        endcase
        if (load_control && hit_s) begin
            dmem_rdata = line_data_s;
        end else begin
            dmem_rdata = {n{1'b0}};
        end
    end

    // Controller FSM and registered bus request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {n{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (store_control) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= address;
                        mem_wdata <= dmem_wdata;
                        state_r   <= ST_WR_THRU;
                    end else if (load_control && !hit_s) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= address;
                        state_r  <= ST_RD_MISS;
                    end
                end
                ST_RD_MISS: begin
                    if (ack_s) begin
                        mem_req <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_WR_THRU: begin
                    if (ack_s) begin
                        mem_req <= 1'b0;
                        state_r <= ST_WR_DONE;
                    end
                end
                ST_WR_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_dcache.sv
// Randomized self-checking bench for l1_dcache against a word-level memory and cache model.
module tb_l1_dcache;
    localparam int N  = 32;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_control;
    logic          store_control;
    logic [AW-1:0] address;
    logic [N-1:0]  dmem_wdata;
    logic [N-1:0]  dmem_rdata;
    logic          L1_busy;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata;
    logic          mem_ack;
    logic [N-1:0]  mem_rdata;
    logic          snoop_inv;
    logic [AW-1:0] snoop_addr;

    int checks = 0;
    int errors = 0;

    // Reference: backing memory plus which word each of the 16 lines holds.
    bit [31:0] memory [bit [14:0]];
    bit        m_valid [16];
    bit [14:0] m_addr  [16];
    bit [31:0] m_data  [16];

    l1_dcache dut (
        .clk           (clk),
        .reset         (reset),
        .load_control  (load_control),
        .store_control (store_control),
        .address       (address),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .L1_busy       (L1_busy),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .snoop_inv     (snoop_inv),
        .snoop_addr    (snoop_addr)
    );

    always #5 clk = ~clk;

    task automatic check_value(string tag, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic bit [31:0] mem_read(bit [14:0] a);
        if (!memory.exists(a)) memory[a] = $urandom;
        return memory[a];
    endfunction

    function automatic bit model_hit(bit [14:0] a);
        return m_valid[a % 16] && (m_addr[a % 16] == a);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endfunction

    // One core access; ack arrives d cycles after mem_req is first seen. Starts/ends just after posedge.
    task automatic access(bit is_store, bit [14:0] a, bit [31:0] wd, int d);
        bit          exp_hit = model_hit(a);
        bit [31:0]   exp_rd;
        int          exp_busy;
        int          busy = 0;
        int          reqc = 0;
        bit          saw = 1'b0;
        bit          done = 1'b0;
        logic [31:0] rd_seen = '0;
        exp_busy = (!is_store && exp_hit) ? 0 : d + 2;
        exp_rd   = exp_hit ? m_data[a % 16] : mem_read(a);
        load_control  = !is_store;
        store_control = is_store;
        address       = a;
        dmem_wdata    = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_req) begin
                if (!saw) begin
                    check_value("bus_we", {31'd0, mem_we}, {31'd0, is_store});
                    check_value("bus_addr", {17'd0, mem_addr}, {17'd0, a});
                    if (is_store) check_value("bus_wdata", mem_wdata, wd);
                end
                saw = 1'b1;
                if (reqc == d) begin
                    mem_ack   = 1'b1;
                    mem_rdata = is_store ? $urandom : memory[a];
                end
                reqc++;
            end
            if (!L1_busy) begin
                done    = 1'b1;
                rd_seen = dmem_rdata;
                check_value("req_low_on_release", {31'd0, mem_req}, 32'd0);
            end else begin
                busy++;
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
        if (!done) check_value("timeout", 32'd0, 32'd1);
        load_control  = 1'b0;
        store_control = 1'b0;
        check_value(is_store ? "store_stall" : "load_stall", busy, exp_busy);
        check_value("bus_used", {31'd0, saw}, {31'd0, (is_store || !exp_hit)});
        if (!is_store) check_value("load_data", rd_seen, exp_rd);
        if (is_store) begin
            memory[a] = wd;
            if (exp_hit) m_data[a % 16] = wd;
        end else if (!exp_hit) begin
            m_valid[a % 16] = 1'b1;
            m_addr[a % 16]  = a;
            m_data[a % 16]  = exp_rd;
        end
    endtask

    task automatic snoop(bit [14:0] a);
        snoop_inv  = 1'b1;
        snoop_addr = a;
        @(posedge clk);
        #1;
        snoop_inv = 1'b0;
        if (model_hit(a)) m_valid[a % 16] = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_control = 1'b0; store_control = 1'b0; address = '0;
        dmem_wdata = '0; mem_ack = 1'b0; mem_rdata = '0; snoop_inv = 1'b0; snoop_addr = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_value("rst_req", {31'd0, mem_req}, 32'd0);
        check_value("rst_we", {31'd0, mem_we}, 32'd0);
        check_value("rst_addr", {17'd0, mem_addr}, 32'd0);
        check_value("rst_wdata", mem_wdata, 32'd0);
        check_value("rst_busy", {31'd0, L1_busy}, 32'd0);
        check_value("rst_rdata", dmem_rdata, 32'd0);
        @(posedge clk);
        #1;

        memory[15'h0010] = 32'hDEADBEEF;
        access(1'b0, 15'h0010, 32'd0, 1);
        access(1'b0, 15'h0010, 32'd0, 1);
        access(1'b1, 15'h0010, 32'h12345678, 2);
        access(1'b0, 15'h0010, 32'd0, 0);
        check_value("updated_line", m_data[0], 32'h12345678);
        snoop(15'h0410);
        access(1'b0, 15'h0010, 32'd0, 1);
        snoop(15'h0010);
        access(1'b0, 15'h0010, 32'd0, 1);
        access(1'b1, 15'h0025, 32'hCAFE0001, 1);
        access(1'b0, 15'h0025, 32'd0, 1);

        // Reset while a read miss is outstanding, then a late ack.
        load_control = 1'b1;
        address      = 15'h0033;
        memory[15'h0033] = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_value("rdmiss_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        load_control = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        check_value("req_after_reset", {31'd0, mem_req}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check_value("late_ack_ignored", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        access(1'b0, 15'h0033, 32'd0, 1);

        for (int i = 0; i < 200; i++) begin
            bit [14:0] a;
            int        op;
            a  = {4'd0, 7'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            op = $urandom_range(0, 9);
            if (op < 5)      access(1'b0, a, 32'd0, $urandom_range(0, 3));
            else if (op < 8) access(1'b1, a, $urandom, $urandom_range(0, 3));
            else             snoop(a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
